tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter N, default 3: number of byte producers sharing one uart_tx; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 255: idle-cycle limit before a held grant is released; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_en  input  N  per-producer byte valid; bit i belongs to producer i.
REQ-006 req_data  input  8*N  per-producer byte; producer i occupies bits [8i+7:8i].
REQ-007 req_last  input  N  marks the presented byte as the final byte of producer i's message.
REQ-008 req_ack  output  N  one-cycle pulse; the byte producer i presented this cycle is consumed.
REQ-009 tx_en  output  1  byte valid toward uart_tx en.
REQ-010 tx_data  output  8  byte toward uart_tx data_in.
REQ-011 tx_ack  input  1  one-cycle accept pulse from uart_tx ack.
REQ-012 grant  output  N  one-hot owner of the transmitter; all-zero when idle.
REQ-013 busy  output  1  high while any grant is held.

Function
REQ-014 Handshake on both sides: a byte transfers on any cycle where en and ack are both high; data and last stay stable while en is high and ack is low.
REQ-015 FSM states: IDLE, LOCK; grant, the owner index, the round-robin pointer and the timeout counter are registered.
REQ-016 IDLE, no req_en bit set: remain in IDLE; grant=0, tx_en=0.
REQ-017 IDLE with req_en nonzero at edge t: select the first set bit searching from pointer+1 upward, modulo N; at t+1 the FSM is in LOCK with grant one-hot on that index.
REQ-018 LOCK with owner g: tx_en=req_en[g], tx_data=req_data[g], req_ack[g]=tx_ack; these three are combinational (zero latency).
REQ-019 In LOCK, req_ack bits for every non-owner are 0; req_en of non-owners has no effect.
REQ-020 In IDLE, req_ack=0 and tx_data=8'h00; tx_ack arriving while tx_en=0 is ignored.
REQ-021 Lock release: at an edge where tx_ack=1, req_en[g]=1 and req_last[g]=1, the next state is IDLE, the pointer loads g and grant clears.
REQ-022 After a release, the earliest next grant is two cycles after the last-byte ack (one IDLE cycle).
REQ-023 Timeout counter: cleared on entry to LOCK and on every transfer; increments each LOCK cycle with req_en[g]=0; saturates.
REQ-024 When the counter reaches TIMEOUT, the next state is IDLE and the pointer loads g; no ack is generated for the abandoned message.
REQ-025 Counter width is the minimum needed to hold TIMEOUT; no wrap-around is permitted.
REQ-026 Release and timeout in the same cycle cannot both occur, because a transfer clears the counter; release takes precedence.
REQ-027 A producer holding req_en across a release re-enters arbitration normally and is not served again while others request (round-robin fairness).
REQ-028 busy equals (state==LOCK); grant is always one-hot or zero.

Reset
REQ-029 rst low forces IDLE, grant=0, busy=0, tx_en=0, req_ack=0, tx_data=8'h00, counter=0 and pointer=N-1, so producer 0 wins the first arbitration.
REQ-030 Reset mid-message abandons the message without an ack; the first grant after rst rises follows REQ-017.
REQ-031 Outputs are reset asynchronously; exit from reset is synchronous to clk.

Verification
REQ-032 After reset, req_en=3'b111, each with a 1-byte message and tx_ack pulsed one cycle after tx_en -> grants occur in the order 0, 1, 2, 0, with one IDLE cycle between grants.
REQ-033 Producer 1 sends "AB" (last on 'B') while producer 0 requests -> tx_data carries 8'h41 then 8'h42 with no interleaving; producer 0 is granted 2 cycles after the 'B' ack.
REQ-034 Owner drops req_en mid-message, TIMEOUT=4 -> busy falls 4 LOCK cycles later, no req_ack is issued, and the pointer advances past the owner.
REQ-035 tx_ack pulsed while IDLE, and while the owner's req_en=0 -> no req_ack and no state change.
REQ-036 rst asserted while LOCK on producer 2 -> grant=0 and tx_en=0 immediately (asynchronously); after release with req_en=3'b101, producer 0 is granted first.

Source files
------------

// File: rtl/tx_arbiter.sv
// Round-robin arbiter letting N byte producers share one uart_tx.
// A grant is held for a whole message and dropped on the last byte or after TIMEOUT idle cycles.
module tx_arbiter #(
    parameter int N       = 3,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_en,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ack,
    output logic           tx_en,
    output logic [7:0]     tx_data,
    input  logic           tx_ack,
    output logic [N-1:0]   grant,
    output logic           busy
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   pointer;
    logic [CW-1:0]   count;

    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic            owner_en;
    logic            owner_last;
    logic            xfer;

    // Next owner: first requester after the last served index, wrapping at N.
    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(pointer) + k) % N;
            if (!sel_found && req_en[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(idx);
            end
        end
    end

    assign owner_en   = req_en[owner];
    assign owner_last = req_last[owner];
    assign xfer       = (state == LOCK) && owner_en && tx_ack;

    assign busy    = (state == LOCK);
    assign tx_en   = (state == LOCK) && owner_en;
    assign tx_data = (state == LOCK) ? req_data[int'(owner)*8 +: 8] : 8'h00;

    always_comb begin
        req_ack = '0;
        if (xfer) begin
            req_ack[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= '0;
            pointer <= IW'(N - 1);
            count   <= '0;
            grant   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state <= LOCK;
                        owner <= sel_idx;
                        grant <= {{(N-1){1'b0}}, 1'b1} << sel_idx;
                        count <= '0;
                    end
                end
                LOCK: begin
                    if (xfer) begin
                        count <= '0;
                        if (owner_last) begin
                            state   <= IDLE;
                            pointer <= owner;
                            grant   <= '0;
                        end
                    end else if (!owner_en) begin
                        // The increment that would reach TIMEOUT releases the grant instead.
                        if (count >= CW'(TIMEOUT - 1)) begin
                            state   <= IDLE;
                            pointer <= owner;
                            grant   <= '0;
                            count   <= CW'(TIMEOUT);
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter (N=3, TIMEOUT=4).
module tb_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_en;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ack;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_ack;
    logic [2:0]  grant;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    tx_arbiter #(.N(3), .TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_en   (req_en),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .tx_ack   (tx_ack),
        .grant    (grant),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] en, input logic [2:0] last, input logic [23:0] data);
        req_en   = en;
        req_last = last;
        req_data = data;
    endtask

    // Grant one single-byte message, ack it a cycle later, then expect one IDLE cycle.
    task automatic serveOne(input int g, input logic [7:0] d);
        tick;
        #1;
        checkOutput("rr_grant", grant, 32'(1 << g));
        checkOutput("rr_data", tx_data, d);
        checkOutput("rr_ack_wait", req_ack, 0);
        tx_ack = 1'b1;
        #1;
        checkOutput("rr_ack", req_ack, 32'(1 << g));
        tick;
        tx_ack = 1'b0;
        #1;
        checkOutput("rr_idle_grant", grant, 0);
        checkOutput("rr_idle_busy", busy, 0);
    endtask

    initial begin
        rst    = 1'b0;
        tx_ack = 1'b0;
        applyStimulus(3'b000, 3'b000, 24'h0);
        #12;
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_tx_en", tx_en, 0);
        checkOutput("rst_req_ack", req_ack, 0);
        checkOutput("rst_tx_data", tx_data, 8'h00);

        // Round robin with all three producers requesting single-byte messages.
        applyStimulus(3'b111, 3'b111, 24'h12_11_10);
        tick;
        checkOutput("rst_hold_grant", grant, 0);
        rst = 1'b1;
        serveOne(0, 8'h10);
        serveOne(1, 8'h11);
        serveOne(2, 8'h12);
        serveOne(0, 8'h10);

        // Producer 1 sends "AB" while producer 0 keeps requesting.
        applyStimulus(3'b011, 3'b001, 24'h00_41_10);
        tick;
        #1;
        checkOutput("ab_grant", grant, 3'b010);
        checkOutput("ab_data_a", tx_data, 8'h41);
        tx_ack = 1'b1;
        #1;
        checkOutput("ab_ack_a", req_ack, 3'b010);
        tick;
        tx_ack = 1'b0;
        applyStimulus(3'b011, 3'b011, 24'h00_42_10);
        #1;
        checkOutput("ab_hold_grant", grant, 3'b010);
        checkOutput("ab_data_b", tx_data, 8'h42);
        checkOutput("ab_no_ack", req_ack, 0);
        tick;
        #1;
        checkOutput("ab_no_interleave", grant, 3'b010);
        tx_ack = 1'b1;
        #1;
        checkOutput("ab_ack_b", req_ack, 3'b010);
        tick;
        tx_ack = 1'b0;
        applyStimulus(3'b001, 3'b001, 24'h00_00_10);
        #1;
        checkOutput("ab_gap_grant", grant, 0);
        tick;
        #1;
        checkOutput("ab_next_grant", grant, 3'b001);
        checkOutput("ab_next_data", tx_data, 8'h10);
        tx_ack = 1'b1;
        tick;
        tx_ack = 1'b0;
        applyStimulus(3'b000, 3'b000, 24'h0);
        #1;
        checkOutput("ab_done_busy", busy, 0);

        // Stray tx_ack while IDLE.
        tx_ack = 1'b1;
        #1;
        checkOutput("idle_ack_req_ack", req_ack, 0);
        checkOutput("idle_ack_tx_en", tx_en, 0);
        checkOutput("idle_ack_tx_data", tx_data, 8'h00);
        tick;
        tx_ack = 1'b0;
        #1;
        checkOutput("idle_ack_busy", busy, 0);

        // Producer 2 abandons its message; grant released after 4 idle LOCK cycles.
        applyStimulus(3'b100, 3'b000, 24'h33_00_00);
        tick;
        #1;
        checkOutput("to_grant", grant, 3'b100);
        applyStimulus(3'b000, 3'b000, 24'h33_00_00);
        tx_ack = 1'b1;
        #1;
        checkOutput("to_stray_ack", req_ack, 0);
        checkOutput("to_tx_en", tx_en, 0);
        for (int i = 1; i <= 3; i++) begin
            tick;
            tx_ack = 1'b0;
            #1;
            checkOutput("to_still_busy", busy, 1);
            checkOutput("to_no_ack", req_ack, 0);
        end
        tick;
        #1;
        checkOutput("to_released_busy", busy, 0);
        checkOutput("to_released_grant", grant, 0);
        applyStimulus(3'b101, 3'b101, 24'h66_00_55);
        tick;
        #1;
        checkOutput("to_ptr_advanced", grant, 3'b001);
        checkOutput("to_next_data", tx_data, 8'h55);
        tx_ack = 1'b1;
        tick;
        tx_ack = 1'b0;

        // Asynchronous reset while producer 2 owns the transmitter.
        applyStimulus(3'b100, 3'b100, 24'h66_00_55);
        tick;
        #1;
        checkOutput("ar_grant", grant, 3'b100);
        checkOutput("ar_tx_en", tx_en, 1);
        tx_ack = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        checkOutput("ar_grant_clear", grant, 0);
        checkOutput("ar_tx_en_clear", tx_en, 0);
        checkOutput("ar_busy_clear", busy, 0);
        checkOutput("ar_no_ack", req_ack, 0);
        tx_ack = 1'b0;
        applyStimulus(3'b101, 3'b101, 24'h66_00_55);
        tick;
        rst = 1'b1;
        tick;
        #1;
        checkOutput("ar_first_grant", grant, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
